switch_accumulator: RTL and testbench
=====================================

SWITCH_ACCUMULATOR -- requirements
Module: switch_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and accumulator width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter DB_CYCLES, default 16, giving the number of consecutive stable cycles needed to accept a button level change (legal range ≥2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port SW, input, WIDTH bits: the operand from the board switches.
REQ-006 The block SHALL have port BTN_ADD, input, 1 bit: raw, bouncy add button.
REQ-007 The block SHALL have port BTN_SUB, input, 1 bit: raw, bouncy subtract button.
REQ-008 The block SHALL have port BTN_CLR, input, 1 bit: raw, bouncy clear button.
REQ-009 The block SHALL have port LED, output, WIDTH+2 bits: [WIDTH-1:0] is the accumulator, [WIDTH] is carry/borrow and [WIDTH+1] is signed overflow.

Function
REQ-010 Each button and each SW bit SHALL pass through a 2-flop synchronizer before use.
REQ-011 Each synchronized button SHALL feed a debouncer whose debounced level flips only after the synchronized input has differed from it for DB_CYCLES consecutive cycles.
REQ-012 The debouncer's difference counter SHALL return to 0 on any cycle where the synchronized input equals the debounced level.
REQ-013 The debouncer SHALL use the FSM states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO; WAIT_* states return to their STABLE_* state when the input reverts before the count completes.
REQ-014 A rising edge of a debounced level SHALL produce exactly one 1-cycle pulse, in the cycle after the level flips; falling edges SHALL produce no pulse.
REQ-015 On an ADD pulse: {LED[WIDTH], acc} SHALL load acc + SW (WIDTH+1-bit sum), with acc wrapping modulo 2^WIDTH.
REQ-016 On a SUB pulse: acc SHALL load acc - SW modulo 2^WIDTH, and LED[WIDTH] SHALL be 1 if and only if acc < SW (unsigned borrow).
REQ-017 On an ADD or SUB pulse, LED[WIDTH+1] SHALL be 1 if and only if the two's-complement result overflows.
REQ-018 On a CLR pulse, acc, carry and overflow SHALL all load 0.
REQ-019 When pulses coincide in one cycle, priority SHALL be CLR > ADD > SUB; only the winning operation executes and the losing pulses are discarded.
REQ-020 The operation SHALL use the synchronized SW value present in the pulse cycle, and the result SHALL be visible on LED in the next cycle.
REQ-021 Flags SHALL hold their value between operations.
REQ-022 The press-to-LED latency for a clean press SHALL be 2 + DB_CYCLES + 2 cycles.
REQ-023 LED SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-024 While rst_n = 0, all of the following SHALL be 0:
  - acc, carry and overflow (LED = 0);
  - synchronizer flops;
  - debounce counters;
  - pulse registers.
REQ-025 While rst_n = 0, all debouncers SHALL be in STABLE_LO.
REQ-026 Reset asserted mid-debounce or mid-operation SHALL abandon it with no pending pulse.
REQ-027 A button held through reset release SHALL yield exactly one pulse, after debounce.

Structure
REQ-028 Package switch_accumulator_pkg SHALL hold the debouncer state enum and the default WIDTH and DB_CYCLES constants.
REQ-029 Synchronizer, debouncer and edge-pulse logic SHALL be one sub-module, btn_debounce (parameter DB_CYCLES), instantiated three times.
REQ-030 The accumulator datapath SHALL be in the top module.

Verification (WIDTH=8, DB_CYCLES=4)
REQ-031 Reset check: assert rst_n=0 with random inputs -> LED=0x000; release with all inputs 0 -> LED stays 0x000.
REQ-032 Add with carry: SW=0x05, clean ADD press -> acc=0x05 exactly 8 cycles after press; then SW=0xFC, ADD -> acc=0x01, carry=1, overflow=0.
REQ-033 Subtract and overflow: acc=0x01, SW=0x02, SUB -> acc=0xFF, borrow=1. Then CLR; SW=0x7F, ADD; SW=0x01, ADD -> acc=0x80, carry=0, overflow=1.
REQ-034 Bounce rejection: ADD toggles every 2 cycles for 12 cycles then held high with SW=0x03 -> exactly one add (acc += 0x03); release bounces produce no operation.
REQ-035 Priority: CLR and ADD pressed on the same cycle -> acc=0x00, flags 0; ADD and SUB on the same cycle -> only the add executes.
REQ-036 Reset mid-debounce: assert rst_n 2 cycles into an ADD debounce -> no pulse; ADD held across reset release -> one add after 8 cycles.

Source files
------------

// File: rtl/switch_accumulator_pkg.sv
// Shared types and default sizing for the switch accumulator and its
// button conditioning.
package switch_accumulator_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DB_CYCLES = 16;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

endpackage

// File: rtl/switch_accumulator_btn_debounce.sv
// One raw button: 2-flop synchronizer, counting debouncer FSM and a
// registered single-cycle pulse on each debounced rising edge.
module btn_debounce
  import switch_accumulator_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level;
  logic          level_dly_q, level_dly_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    // The first differing cycle is counted on entry to WAIT_*, so the level
    // flips on the DB_CYCLES-th consecutive differing cycle.
    case (state_q)
      STABLE_LO: if (sync2_q) begin
        state_d = WAIT_HI;
        cnt_d   = CW'(1);
      end
      WAIT_HI: begin
        if (!sync2_q)               state_d = STABLE_LO;
        else if (cnt_q == CNT_LAST) state_d = STABLE_HI;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      STABLE_HI: if (!sync2_q) begin
        state_d = WAIT_LO;
        cnt_d   = CW'(1);
      end
      WAIT_LO: begin
        if (sync2_q)                state_d = STABLE_HI;
        else if (cnt_q == CNT_LAST) state_d = STABLE_LO;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = STABLE_LO;
    endcase

    level       = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    level_dly_d = level;
    pulse_d     = level & ~level_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= STABLE_LO;
      cnt_q       <= '0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/switch_accumulator.sv
// Switch-operand accumulator: debounced ADD/SUB/CLR buttons update a
// registered accumulator with carry/borrow and signed-overflow flags.
module switch_accumulator
  import switch_accumulator_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SW,
  input  logic             BTN_ADD,
  input  logic             BTN_SUB,
  input  logic             BTN_CLR,
  output logic [WIDTH+1:0] LED
);

  logic [WIDTH-1:0] sw_s1_q, sw_s1_d;
  logic [WIDTH-1:0] sw_s2_q, sw_s2_d;
  logic             add_pulse, sub_pulse, clr_pulse;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum, diff;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_add (
    .clk(clk), .rst_n(rst_n), .btn_raw(BTN_ADD), .pulse(add_pulse)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sub (
    .clk(clk), .rst_n(rst_n), .btn_raw(BTN_SUB), .pulse(sub_pulse)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_raw(BTN_CLR), .pulse(clr_pulse)
  );

  always_comb begin
    sw_s1_d = SW;
    sw_s2_d = sw_s1_q;
    sum     = {1'b0, acc_q} + {1'b0, sw_s2_q};
    diff    = {1'b0, acc_q} - {1'b0, sw_s2_q};
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    // CLR wins over ADD, ADD over SUB; losers are simply dropped.
    if (clr_pulse) begin
      acc_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (add_pulse) begin
      acc_d   = sum[WIDTH-1:0];
      carry_d = sum[WIDTH];
      ovf_d   = (acc_q[WIDTH-1] == sw_s2_q[WIDTH-1]) &&
                (sum[WIDTH-1] != acc_q[WIDTH-1]);
    end else if (sub_pulse) begin
      acc_d   = diff[WIDTH-1:0];
      carry_d = diff[WIDTH];
      ovf_d   = (acc_q[WIDTH-1] != sw_s2_q[WIDTH-1]) &&
                (diff[WIDTH-1] != acc_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign LED = {ovf_q, carry_q, acc_q};

endmodule

// File: tb/tb_switch_accumulator.sv
// Directed and randomized checks of switch_accumulator against an
// arithmetic reference model (WIDTH=8, DB_CYCLES=4).
`timescale 1ns/1ps
module tb_switch_accumulator;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] SW;
  logic         BTN_ADD, BTN_SUB, BTN_CLR;
  logic [W+1:0] LED;

  int total = 0;
  int bad   = 0;
  int m_acc = 0, m_c = 0, m_v = 0;

  switch_accumulator #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW),
    .BTN_ADD(BTN_ADD), .BTN_SUB(BTN_SUB), .BTN_CLR(BTN_CLR), .LED(LED)
  );

  always #5 clk = ~clk;

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic logic [W+1:0] exp_led();
    return {m_v[0], m_c[0], m_acc[7:0]};
  endfunction

  // btns: [0]=ADD [1]=SUB [2]=CLR; CLR > ADD > SUB
  task automatic model_op(input logic [2:0] btns, input int sw);
    int r;
    if (btns[2]) begin
      m_acc = 0; m_c = 0; m_v = 0;
    end else if (btns[0]) begin
      r     = sx(m_acc) + sx(sw);
      m_v   = (r > 127 || r < -128) ? 1 : 0;
      m_c   = (m_acc + sw > 255) ? 1 : 0;
      m_acc = (m_acc + sw) % 256;
    end else if (btns[1]) begin
      r     = sx(m_acc) - sx(sw);
      m_v   = (r > 127 || r < -128) ? 1 : 0;
      m_c   = (m_acc < sw) ? 1 : 0;
      m_acc = (m_acc - sw + 256) % 256;
    end
  endtask

  task automatic chk(input string tag, input logic [W+1:0] got, input logic [W+1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic set_btns(input logic [2:0] b);
    BTN_ADD = b[0]; BTN_SUB = b[1]; BTN_CLR = b[2];
  endtask

  // Clean press: LED must hold for 7 edges and update on the 8th.
  task automatic press(input logic [2:0] btns, input logic [7:0] sw, input string tag);
    @(negedge clk);
    SW = sw;
    set_btns(btns);
    repeat (2 + DB + 1) @(posedge clk);
    #1 chk({tag, "_early"}, LED, exp_led());
    @(posedge clk);
    model_op(btns, int'(sw));
    #1 chk(tag, LED, exp_led());
    @(negedge clk);
    set_btns(3'b000);
    repeat (DB + 8) @(negedge clk);
    chk({tag, "_release"}, LED, exp_led());
  endtask

  initial begin
    rst_n = 1'b0;
    SW = W'($urandom);
    set_btns(3'($urandom));
    repeat (3) @(negedge clk);
    SW = W'($urandom);
    set_btns(3'b111);
    repeat (2) @(negedge clk);
    chk("reset_hold", LED, '0);
    SW = '0;
    set_btns(3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_release", LED, '0);

    press(3'b001, 8'h05, "add_05");
    press(3'b001, 8'hFC, "add_carry");
    chk("add_carry_val", LED, 10'h101);

    press(3'b010, 8'h02, "sub_borrow");
    chk("sub_borrow_val", LED, 10'h1FF);
    press(3'b100, 8'h00, "clr");
    press(3'b001, 8'h7F, "add_7f");
    press(3'b001, 8'h01, "add_ovf");
    chk("add_ovf_val", LED, 10'h280);

    // Bouncy press: toggle every 2 cycles, then hold high.
    @(negedge clk);
    SW = 8'h03;
    repeat (6) begin
      BTN_ADD = ~BTN_ADD;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("bounce_press_noop", LED, exp_led());
    BTN_ADD = 1'b1;
    repeat (20) @(negedge clk);
    model_op(3'b001, 3);
    chk("bounce_one_add", LED, exp_led());
    repeat (6) begin
      BTN_ADD = ~BTN_ADD;
      repeat (2) @(negedge clk);
    end
    BTN_ADD = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_release_noop", LED, exp_led());

    press(3'b101, 8'h55, "prio_clr_add");
    chk("prio_clr_val", LED, 10'h000);
    press(3'b011, 8'h10, "prio_add_sub");
    chk("prio_add_val", LED, 10'h010);

    // Reset two cycles into an ADD debounce, button kept held.
    @(negedge clk);
    SW = 8'h22;
    BTN_ADD = 1'b1;
    repeat (2 + 2) @(posedge clk);
    #1 rst_n = 1'b0;
    model_op(3'b100, 0);
    repeat (2) @(negedge clk);
    chk("midreset_clear", LED, '0);
    rst_n = 1'b1;
    repeat (2 + DB + 1) @(posedge clk);
    #1 chk("midreset_early", LED, '0);
    @(posedge clk);
    model_op(3'b001, 8'h22);
    #1 chk("midreset_held_add", LED, exp_led());
    repeat (10) @(negedge clk);
    BTN_ADD = 1'b0;
    repeat (DB + 8) @(negedge clk);
    chk("midreset_single", LED, 10'h022);

    for (int i = 0; i < 24; i++) begin
      int r;
      logic [2:0] b;
      r = int'($urandom_range(0, 9));
      b = (r == 0) ? 3'b100 : (r <= 5) ? 3'b001 : 3'b010;
      press(b, 8'($urandom), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
